// File: rtl/instr_fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
//   RW          : PC / memory address width
//   INSTR_W_DEF : default instruction word width
//   fetch_state_t : fetch controller state encoding
package instr_fetch_pkg;

    localparam int RW          = 16;
    localparam int INSTR_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between the memory return path and decode.
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_push/i_push_data : write one entry at the tail
//   i_pop              : drop the head entry
//   i_flush            : empty the buffer (wins over push/pop)
//   o_head             : head entry (registered storage, zero after reset)
//   o_count            : number of valid entries
//   o_full, o_empty    : occupancy flags
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 48
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads instruction memory at the current PC, buffers the
// returned words and hands {instruction, pc} pairs to decode.
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_pc                    : current PC
//   i_flush                 : PC reload this cycle (branch/IRQ)
//   o_c_pc_inc              : PC increment pulse, one per kept fetch
//   o_mem_req, o_mem_addr   : memory read request and address
//   i_mem_ack, i_mem_data   : single-cycle acknowledge with read data
//   o_instr, o_instr_pc     : buffer head instruction and its address
//   o_valid, i_ready        : handshake towards decode
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | request at r_addr outstanding, data will be kept
// DROP  | flushed request still outstanding, data will be discarded
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [RW-1:0]      i_pc,
    input  logic               i_flush,
    output logic               o_c_pc_inc,
    output logic               o_mem_req,
    output logic [RW-1:0]      o_mem_addr,
    input  logic               i_mem_ack,
    input  logic [INSTR_W-1:0] i_mem_data,
    output logic [INSTR_W-1:0] o_instr,
    output logic [RW-1:0]      o_instr_pc,
    output logic               o_valid,
    input  logic               i_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INSTR_W + RW;

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [RW-1:0] r_addr;
    logic [RW-1:0] w_addr_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_inc;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [EW-1:0] w_head;

    assign w_pop = o_valid & i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_push      = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // launch only when a slot is guaranteed for the returning word
                if (!i_flush && (!w_full || w_pop)) begin
                    w_state_nxt = ST_WAIT;
                    w_addr_nxt  = i_pc;
                end
            end
            ST_WAIT: begin
                if (i_flush) begin
                    // address stays put so the outstanding request is held stable
                    w_state_nxt = i_mem_ack ? ST_IDLE : ST_DROP;
                end else if (i_mem_ack) begin
                    w_push = 1'b1;
                    w_inc  = 1'b1;
                    if ((w_count + CW'(1) - CW'(w_pop)) < CW'(DEPTH)) begin
                        w_addr_nxt = r_addr + RW'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (i_mem_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data ({i_mem_data, r_addr}),
        .i_pop       (w_pop),
        .i_flush     (i_flush),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign o_valid    = ~w_empty;
    assign o_instr    = w_head[EW-1:RW];
    assign o_instr_pc = w_head[RW-1:0];
    assign o_mem_req  = (r_state != ST_IDLE);
    assign o_mem_addr = o_mem_req ? r_addr : '0;
    assign o_c_pc_inc = w_inc;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_pc;
    logic        i_flush;
    logic        o_c_pc_inc;
    logic        o_mem_req;
    logic [15:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic [31:0] o_instr;
    logic [15:0] o_instr_pc;
    logic        o_valid;
    logic        i_ready;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(
        .DEPTH   (2),
        .INSTR_W (32)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_pc       (i_pc),
        .i_flush    (i_flush),
        .o_c_pc_inc (o_c_pc_inc),
        .o_mem_req  (o_mem_req),
        .o_mem_addr (o_mem_addr),
        .i_mem_ack  (i_mem_ack),
        .i_mem_data (i_mem_data),
        .o_instr    (o_instr),
        .o_instr_pc (o_instr_pc),
        .o_valid    (o_valid),
        .i_ready    (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        flush;
        logic        ack;
        logic        ready;
        logic [15:0] dlo;
        logic        ereq;
        logic [15:0] eaddr;
        logic        einc;
        logic        evalid;
        logic [15:0] eipc;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic [15:0] pc, input logic f, input logic a,
                                input logic r, input logic [15:0] d, input logic ereq,
                                input logic [15:0] eaddr, input logic einc,
                                input logic evalid, input logic [15:0] eipc);
        vec_t v;
        v.pc = pc; v.flush = f; v.ack = a; v.ready = r; v.dlo = d;
        v.ereq = ereq; v.eaddr = eaddr; v.einc = einc; v.evalid = evalid; v.eipc = eipc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Memory data is tagged with its address so o_instr can be predicted from o_instr_pc.
    task automatic cyc(input string tag, input logic [15:0] pc, input logic f, input logic a,
                       input logic r, input logic [15:0] d, input logic ereq,
                       input logic [15:0] eaddr, input logic einc, input logic evalid,
                       input logic [15:0] eipc);
        @(negedge clk);
        i_pc       = pc;
        i_flush    = f;
        i_mem_ack  = a;
        i_ready    = r;
        i_mem_data = {16'hA5A5, d};
        #1;
        chk({tag, ".req"},   32'(o_mem_req),  32'(ereq));
        chk({tag, ".addr"},  32'(o_mem_addr), 32'(eaddr));
        chk({tag, ".inc"},   32'(o_c_pc_inc), 32'(einc));
        chk({tag, ".valid"}, 32'(o_valid),    32'(evalid));
        if (evalid) begin
            chk({tag, ".ipc"},   32'(o_instr_pc), 32'(eipc));
            chk({tag, ".instr"}, o_instr,         {16'hA5A5, eipc});
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req"},   32'(o_mem_req),  32'h0);
        chk({tag, ".addr"},  32'(o_mem_addr), 32'h0);
        chk({tag, ".inc"},   32'(o_c_pc_inc), 32'h0);
        chk({tag, ".valid"}, 32'(o_valid),    32'h0);
        chk({tag, ".ipc"},   32'(o_instr_pc), 32'h0);
        chk({tag, ".instr"}, o_instr,         32'h0);
    endtask

    initial begin
        //            pc      f  a  r  data     req addr    inc v  ipc
        tbl[0]  = mk(16'h10, 0, 0, 1, 16'h0,    0, 16'h0,  0, 0, 16'h0);
        tbl[1]  = mk(16'h10, 0, 1, 1, 16'h10,   1, 16'h10, 1, 0, 16'h0);
        tbl[2]  = mk(16'h11, 0, 1, 1, 16'h11,   1, 16'h11, 1, 1, 16'h10);
        tbl[3]  = mk(16'h12, 0, 1, 1, 16'h12,   1, 16'h12, 1, 1, 16'h11);
        tbl[4]  = mk(16'h13, 0, 0, 1, 16'h0,    1, 16'h13, 0, 1, 16'h12);
        tbl[5]  = mk(16'h13, 0, 0, 1, 16'h0,    1, 16'h13, 0, 0, 16'h0);
        tbl[6]  = mk(16'h13, 0, 1, 0, 16'h13,   1, 16'h13, 1, 0, 16'h0);
        tbl[7]  = mk(16'h14, 0, 1, 0, 16'h14,   1, 16'h14, 1, 1, 16'h13);
        tbl[8]  = mk(16'h15, 0, 1, 0, 16'hDEAD, 0, 16'h0,  0, 1, 16'h13);
        tbl[9]  = mk(16'h15, 0, 0, 0, 16'h0,    0, 16'h0,  0, 1, 16'h13);
        tbl[10] = mk(16'h15, 0, 0, 1, 16'h0,    0, 16'h0,  0, 1, 16'h13);
        tbl[11] = mk(16'h15, 0, 1, 1, 16'h15,   1, 16'h15, 1, 1, 16'h14);
        tbl[12] = mk(16'h16, 0, 0, 0, 16'h0,    1, 16'h16, 0, 1, 16'h15);

        rst_n      = 1'b0;
        i_pc       = 16'h0;
        i_flush    = 1'b0;
        i_mem_ack  = 1'b0;
        i_mem_data = 32'h0;
        i_ready    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");

        // hold flush while leaving reset so IDLE does not launch before vector 0
        @(negedge clk);
        rst_n   = 1'b1;
        i_flush = 1'b1;

        // streaming, back-pressure fill to DEPTH, stray ack in IDLE, resume
        for (int i = 0; i < 13; i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].pc, tbl[i].flush, tbl[i].ack, tbl[i].ready,
                tbl[i].dlo, tbl[i].ereq, tbl[i].eaddr, tbl[i].einc, tbl[i].evalid, tbl[i].eipc);
        end

        // flush while waiting: request held until the late ack, data dropped
        cyc("fl0", 16'h16,  1, 0, 0, 16'hDEAD, 1, 16'h16,  0, 1, 16'h15);
        cyc("fl1", 16'h200, 0, 0, 0, 16'h0,    1, 16'h16,  0, 0, 16'h0);
        cyc("fl2", 16'h200, 1, 0, 0, 16'h0,    1, 16'h16,  0, 0, 16'h0);
        cyc("fl3", 16'h200, 0, 1, 0, 16'hDEAD, 1, 16'h16,  0, 0, 16'h0);
        cyc("fl4", 16'h200, 0, 0, 0, 16'h0,    0, 16'h0,   0, 0, 16'h0);
        cyc("fl5", 16'h200, 0, 1, 0, 16'h200,  1, 16'h200, 1, 0, 16'h0);

        // flush coincident with ack while one entry is buffered
        cyc("fa0", 16'h201, 1, 1, 0, 16'hDEAD, 1, 16'h201, 0, 1, 16'h200);
        cyc("fa1", 16'h300, 0, 0, 0, 16'h0,    0, 16'h0,   0, 0, 16'h0);
        cyc("fa2", 16'h300, 0, 1, 0, 16'h300,  1, 16'h300, 1, 0, 16'h0);
        cyc("fa3", 16'h301, 0, 0, 1, 16'h0,    1, 16'h301, 0, 1, 16'h300);

        // address wrap 0xFFFF -> 0x0000 during back-to-back fetch
        cyc("wr0", 16'h301,  1, 0, 1, 16'h0,    1, 16'h301,  0, 0, 16'h0);
        cyc("wr1", 16'hFFFF, 0, 1, 1, 16'hDEAD, 1, 16'h301,  0, 0, 16'h0);
        cyc("wr2", 16'hFFFF, 0, 0, 1, 16'h0,    0, 16'h0,    0, 0, 16'h0);
        cyc("wr3", 16'hFFFF, 0, 1, 1, 16'hFFFF, 1, 16'hFFFF, 1, 0, 16'h0);
        cyc("wr4", 16'h0000, 0, 1, 1, 16'h0000, 1, 16'h0000, 1, 1, 16'hFFFF);
        cyc("wr5", 16'h0001, 0, 0, 0, 16'h0,    1, 16'h0001, 0, 1, 16'h0000);

        // async reset mid-WAIT with a buffered entry, ack pending
        @(negedge clk);
        i_mem_ack  = 1'b1;
        i_mem_data = 32'hDEADBEEF;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");

        // stray ack right after release must not push or pulse the PC
        @(negedge clk);
        rst_n      = 1'b1;
        i_pc       = 16'h40;
        i_ready    = 1'b1;
        i_mem_ack  = 1'b1;
        #1;
        chk("rel.inc",   32'(o_c_pc_inc), 32'h0);
        chk("rel.req",   32'(o_mem_req),  32'h0);
        chk("rel.valid", 32'(o_valid),    32'h0);
        cyc("rs2", 16'h40, 0, 0, 1, 16'h0,  1, 16'h40, 0, 0, 16'h0);
        cyc("rs3", 16'h40, 0, 1, 1, 16'h40, 1, 16'h40, 1, 0, 16'h0);
        cyc("rs4", 16'h41, 0, 0, 1, 16'h0,  1, 16'h41, 0, 1, 16'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
